// File: rtl/gremlin_spawn_ctl_pkg.sv
// Shared constants for the gremlin spawn scheduler: slot state encodings,
// default slot count and the frame LFSR step.
package gremlin_spawn_ctl_pkg;

    localparam int GREM_N_DEFAULT = 2;

    localparam logic [1:0] GS_IDLE  = 2'd0;
    localparam logic [1:0] GS_ALIVE = 2'd1;
    localparam logic [1:0] GS_DEAD  = 2'd2;

    // Fibonacci taps 8,6,5,4 as a mask over bits [7:0]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef logic [7:0] frame_timer_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/gremlin_slot_ctl.sv
// One gremlin slot: IDLE -> ALIVE on game start, ALIVE -> DEAD on hit,
// DEAD counts frame ticks down to respawn. game_on low forces IDLE.
module gremlin_slot_ctl
    import gremlin_spawn_ctl_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         game_on_i,
    input  logic         game_start_i,
    input  logic         frame_tick_i,
    input  logic         hit_i,
    input  frame_timer_t load_val_i,
    output logic         enable_o,
    output logic         hit_acc_o
);

    logic [1:0]   state_q, state_d;
    frame_timer_t timer_q, timer_d;
    logic         enable_q;

    assign hit_acc_o = game_on_i & hit_i & (state_q == GS_ALIVE);
    assign enable_o  = enable_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!game_on_i) begin
            state_d = GS_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                GS_IDLE: begin
                    if (game_start_i) state_d = GS_ALIVE;
                end
                GS_ALIVE: begin
                    if (hit_i) begin
                        state_d = GS_DEAD;
                        timer_d = load_val_i;
                    end
                end
                GS_DEAD: begin
                    // timer <= 1 also covers a zero load, so a slot can never stick dead
                    if (frame_tick_i) begin
                        if (timer_q <= 8'd1) begin
                            state_d = GS_ALIVE;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = GS_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= GS_IDLE;
            timer_q  <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            enable_q <= (state_d == GS_ALIVE);
        end
    end

endmodule

// File: rtl/gremlin_spawn_ctl.sv
// Frame-based gremlin scheduler: vsync/game_on edge detect, delay LFSR,
// per-slot FSMs and the saturating kill score.
module gremlin_spawn_ctl
    import gremlin_spawn_ctl_pkg::*;
#(
    parameter int         N_GREM       = GREM_N_DEFAULT,
    parameter int         RESPAWN_BASE = 60,
    parameter bit         RAND_EN      = 1'b1,
    parameter int         RAND_BITS    = 5,
    parameter int         SCORE_W      = 10,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
)(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               game_on_i,
    input  logic               vsync_in_i,
    input  logic [N_GREM-1:0]  grem_hit_i,
    output logic [N_GREM-1:0]  grem_enable_o,
    output logic [SCORE_W-1:0] score_o,
    output logic               kill_pulse_o
);

    localparam int           CNT_W     = $clog2(N_GREM + 1);
    localparam int           SUM_W     = SCORE_W + CNT_W;
    localparam logic [7:0]   RAND_MASK = 8'((1 << RAND_BITS) - 1);
    localparam logic [7:0]   BASE_VAL  = 8'(RESPAWN_BASE);
    localparam logic [SUM_W-1:0] SCORE_MAX = {{CNT_W{1'b0}}, {SCORE_W{1'b1}}};

    logic               vsync_q;
    logic               game_on_q;
    logic [7:0]         lfsr_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               kill_q;

    logic               frame_tick;
    logic               game_start;
    frame_timer_t       load_val;
    logic [N_GREM-1:0]  hit_acc;
    logic [N_GREM-1:0]  enable;
    logic [CNT_W-1:0]   hit_cnt;
    logic [SUM_W-1:0]   score_sum;

    assign frame_tick = vsync_in_i & ~vsync_q;
    assign game_start = game_on_i & ~game_on_q;
    assign load_val   = BASE_VAL + (RAND_EN ? (lfsr_q & RAND_MASK) : 8'd0);

    for (genvar g = 0; g < N_GREM; g++) begin : g_slot
        gremlin_slot_ctl u_slot (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .game_on_i    (game_on_i),
            .game_start_i (game_start),
            .frame_tick_i (frame_tick),
            .hit_i        (grem_hit_i[g]),
            .load_val_i   (load_val),
            .enable_o     (enable[g]),
            .hit_acc_o    (hit_acc[g])
        );
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < N_GREM; i++) begin
            hit_cnt = hit_cnt + CNT_W'(hit_acc[i]);
        end
        score_sum = {{CNT_W{1'b0}}, score_q} + {{SCORE_W{1'b0}}, hit_cnt};
        score_d   = score_q;
        if (game_start) begin
            score_d = '0;
        end else if (score_sum > SCORE_MAX) begin
            score_d = '1;
        end else begin
            score_d = score_sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vsync_q   <= 1'b0;
            game_on_q <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            score_q   <= '0;
            kill_q    <= 1'b0;
        end else begin
            vsync_q   <= vsync_in_i;
            game_on_q <= game_on_i;
            lfsr_q    <= lfsr_next(lfsr_q);
            score_q   <= score_d;
            kill_q    <= |hit_acc;
        end
    end

    assign grem_enable_o = enable;
    assign score_o       = score_q;
    assign kill_pulse_o  = kill_q;

endmodule
